// File: rtl/period_meter_pkg.sv
// Shared definitions for the period meter: FSM state encoding and synchroniser limits.
package period_meter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        MEASURE = 2'd2
    } state_t;

    localparam int SYNC_MIN = 2;

endpackage

// File: rtl/period_meter_sync_edge_detect.sv
// Brings an asynchronous signal into the clock domain and flags its rising/falling edges.
module sync_edge_detect #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic sig,
    output logic rise_pulse,
    output logic fall_pulse
);

    logic [STAGES-1:0] sync_reg;
    logic              edge_reg;
    logic [STAGES:0]   primed_reg;
    logic              primed;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_reg   <= '0;
            edge_reg   <= 1'b0;
            primed_reg <= '0;
        end else begin
            sync_reg   <= {sync_reg[STAGES-2:0], sig};
            edge_reg   <= sync_reg[STAGES-1];
            primed_reg <= {primed_reg[STAGES-1:0], 1'b1};
        end
    end

    // Edges are masked until the edge flop holds a real sample, so a signal that is
    // already high when reset releases is not mistaken for a rising edge.
    assign primed     = primed_reg[STAGES];
    assign rise_pulse = primed &  sync_reg[STAGES-1] & ~edge_reg;
    assign fall_pulse = primed & ~sync_reg[STAGES-1] &  edge_reg;

endmodule

// File: rtl/period_meter.sv
// Measures period and high time of an asynchronous signal in clock cycles.
module period_meter
    import period_meter_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic             CLK_in,
    input  logic             RST_in,
    input  logic             EN_in,
    input  logic             SIG_in,
    output logic [WIDTH-1:0] PERIOD_out,
    output logic [WIDTH-1:0] HIGH_out,
    output logic             VALID_out,
    output logic             TIMEOUT_out,
    output logic             BUSY_out
);

    localparam int               STAGES  = (SYNC_STAGES < SYNC_MIN) ? SYNC_MIN : SYNC_STAGES;
    localparam logic [WIDTH-1:0] CNT_MAX = '1;
    localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

    state_t           state_reg;
    logic [WIDTH-1:0] cnt_reg;
    logic [WIDTH-1:0] high_reg;
    logic             high_seen_reg;
    logic             rise;
    logic             fall;

    sync_edge_detect #(
        .STAGES(STAGES)
    ) u_sync (
        .clk       (CLK_in),
        .rst       (RST_in),
        .sig       (SIG_in),
        .rise_pulse(rise),
        .fall_pulse(fall)
    );

    always_ff @(posedge CLK_in or posedge RST_in) begin
        if (RST_in) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            high_reg      <= '0;
            high_seen_reg <= 1'b0;
            PERIOD_out    <= '0;
            HIGH_out      <= '0;
            VALID_out     <= 1'b0;
            TIMEOUT_out   <= 1'b0;
        end else begin
            VALID_out   <= 1'b0;
            TIMEOUT_out <= 1'b0;
            if (!EN_in) begin
                state_reg     <= IDLE;
                cnt_reg       <= '0;
                high_reg      <= '0;
                high_seen_reg <= 1'b0;
            end else begin
                case (state_reg)
                    IDLE: state_reg <= ARM;
                    ARM: begin
                        if (rise) begin
                            state_reg     <= MEASURE;
                            cnt_reg       <= CNT_ONE;
                            high_reg      <= '0;
                            high_seen_reg <= 1'b0;
                        end
                    end
                    MEASURE: begin
                        // A rising edge closes the period even when the counter is saturated.
                        if (rise) begin
                            PERIOD_out    <= cnt_reg;
                            HIGH_out      <= high_seen_reg ? high_reg : cnt_reg;
                            VALID_out     <= 1'b1;
                            cnt_reg       <= CNT_ONE;
                            high_reg      <= '0;
                            high_seen_reg <= 1'b0;
                        end else if (cnt_reg == CNT_MAX) begin
                            TIMEOUT_out   <= 1'b1;
                            state_reg     <= ARM;
                            cnt_reg       <= '0;
                            high_reg      <= '0;
                            high_seen_reg <= 1'b0;
                        end else begin
                            cnt_reg <= cnt_reg + CNT_ONE;
                            if (fall && !high_seen_reg) begin
                                high_reg      <= cnt_reg;
                                high_seen_reg <= 1'b1;
                            end
                        end
                    end
                    default: state_reg <= IDLE;
                endcase
            end
        end
    end

    assign BUSY_out = (state_reg != IDLE);

endmodule

// File: tb/tb_period_meter.sv
// Randomized and directed checks of period_meter against a timestamp-based reference model.
module tb_period_meter;

    localparam int W    = 8;
    localparam int S    = 2;
    localparam int MAXC = (1 << W) - 1;

    logic         clk = 1'b0;
    logic         rst;
    logic         en;
    logic         sig;
    logic [W-1:0] period;
    logic [W-1:0] high;
    logic         valid;
    logic         timeout;
    logic         busy;

    always #5 clk = ~clk;

    period_meter #(
        .WIDTH      (W),
        .SYNC_STAGES(S)
    ) dut (
        .CLK_in     (clk),
        .RST_in     (rst),
        .EN_in      (en),
        .SIG_in     (sig),
        .PERIOD_out (period),
        .HIGH_out   (high),
        .VALID_out  (valid),
        .TIMEOUT_out(timeout),
        .BUSY_out   (busy)
    );

    int checks = 0;
    int errors = 0;
    int valid_cnt = 0;
    int timeout_cnt = 0;
    int cyc = 0;
    int last_valid_cyc = 0;
    int last_interval = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: tracks sampled signal history and timestamps of the last
    // rising edge and first falling edge, deriving results by subtraction.
    int m_mode;            // 0 idle, 1 armed, 2 measuring
    int m_edges;
    int m_start;
    int m_fall_at;
    int e_period;
    int e_high;
    bit e_valid;
    bit e_timeout;
    bit hist [0:S];

    always @(posedge clk or posedge rst) begin
        bit r;
        bit f;
        int el;
        if (rst) begin
            m_mode = 0; m_edges = 0; m_start = 0; m_fall_at = -1;
            e_period = 0; e_high = 0; e_valid = 0; e_timeout = 0;
            for (int i = 0; i <= S; i++) hist[i] = 1'b0;
        end else begin
            r = (m_edges >= S + 1) && hist[S-1] && !hist[S];
            f = (m_edges >= S + 1) && !hist[S-1] && hist[S];
            for (int i = S; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = sig;
            m_edges++;
            e_valid = 0;
            e_timeout = 0;
            if (!en) begin
                m_mode = 0;
            end else if (m_mode == 0) begin
                m_mode = 1;
            end else if (m_mode == 1) begin
                if (r) begin m_mode = 2; m_start = m_edges; m_fall_at = -1; end
            end else begin
                el = m_edges - m_start;
                if (r) begin
                    e_period = el;
                    e_high   = (m_fall_at >= 0) ? (m_fall_at - m_start) : el;
                    e_valid  = 1;
                    m_start  = m_edges;
                    m_fall_at = -1;
                end else if (el == MAXC) begin
                    e_timeout = 1;
                    m_mode = 1;
                end else if (f && m_fall_at < 0) begin
                    m_fall_at = m_edges;
                end
            end
        end
    end

    always @(negedge clk) begin
        cyc++;
        check("valid",   32'(valid),   32'(e_valid));
        check("timeout", 32'(timeout), 32'(e_timeout));
        check("busy",    32'(busy),    32'(m_mode != 0));
        check("period",  32'(period),  32'(e_period));
        check("high",    32'(high),    32'(e_high));
        if (valid) begin
            valid_cnt++;
            last_interval = cyc - last_valid_cyc;
            last_valid_cyc = cyc;
        end
        if (timeout) timeout_cnt++;
    end

    // Starts at posedge+phase with the rising edge; ends at posedge+phase of the next one.
    task automatic wave(input int p, input int h, input int n, input int phase);
        repeat (n) begin
            sig = 1'b1;
            repeat (h) @(posedge clk);
            #phase;
            sig = 1'b0;
            repeat (p - h) @(posedge clk);
            #phase;
        end
    endtask

    task automatic align(input int phase);
        @(posedge clk);
        #phase;
    endtask

    int v0;
    int t0;

    initial begin
        rst = 1'b1; en = 1'b0; sig = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        check("rst_period", 32'(period), 0);
        check("rst_busy",   32'(busy),   0);
        repeat (4) @(posedge clk);

        // 16-cycle wave, 8 high
        #3 en = 1'b1;
        align(3);
        v0 = valid_cnt;
        wave(16, 8, 1, 3);
        check("sq16_no_valid_first_rise", 32'(valid_cnt - v0), 0);
        wave(16, 8, 6, 3);
        check("sq16_valid_count", 32'(valid_cnt - v0), 6);
        check("sq16_period", 32'(period), 16);
        check("sq16_high",   32'(high),   8);
        check("sq16_interval", 32'(last_interval), 16);

        // 10-cycle wave, 3 high, different phase
        align(7);
        wave(10, 3, 5, 7);
        check("p10_period", 32'(period), 10);
        check("p10_high",   32'(high),   3);

        // one rising edge then held low: single timeout, outputs unchanged
        t0 = timeout_cnt;
        sig = 1'b1;
        repeat (3) @(posedge clk);
        #7 sig = 1'b0;
        repeat (300) @(posedge clk);
        #3;
        check("to_count",  32'(timeout_cnt - t0), 1);
        check("to_period", 32'(period), 10);
        check("to_high",   32'(high),   3);
        check("to_busy",   32'(busy),   1);

        // enable dropped mid-period
        wave(12, 5, 3, 3);
        sig = 1'b1;
        repeat (4) @(posedge clk);
        #3 en = 1'b0;
        v0 = valid_cnt;
        repeat (3) @(posedge clk);
        #3 en = 1'b1;
        repeat (2) @(posedge clk);
        #3 sig = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        wave(12, 5, 1, 3);
        check("en_no_valid",  32'(valid_cnt - v0), 0);
        check("en_hold_period", 32'(period), 12);
        check("en_hold_high",   32'(high),   5);
        wave(12, 5, 3, 3);
        check("en_valid_count", 32'(valid_cnt - v0), 3);

        // asynchronous reset mid-measurement
        wave(16, 8, 2, 3);
        sig = 1'b1;
        repeat (5) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("arst_period",  32'(period),  0);
        check("arst_high",    32'(high),    0);
        check("arst_valid",   32'(valid),   0);
        check("arst_timeout", 32'(timeout), 0);
        check("arst_busy",    32'(busy),    0);
        sig = 1'b0;
        #3 rst = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        v0 = valid_cnt;
        wave(16, 8, 1, 3);
        check("arst_no_valid_first_rise", 32'(valid_cnt - v0), 0);
        wave(16, 8, 2, 3);
        check("arst_valid_count", 32'(valid_cnt - v0), 2);
        check("arst_sq16_period", 32'(period), 16);

        // signal constant high out of reset
        #1 rst = 1'b1;
        sig = 1'b1;
        #4 rst = 1'b0;
        v0 = valid_cnt;
        t0 = timeout_cnt;
        repeat (400) @(posedge clk);
        #3;
        check("hi_no_valid",   32'(valid_cnt - v0),   0);
        check("hi_no_timeout", 32'(timeout_cnt - t0), 0);
        check("hi_busy",       32'(busy), 1);
        sig = 1'b0;

        // randomized periods, duty cycles, phases and enable drops
        for (int k = 0; k < 20; k++) begin
            int p;
            int h;
            int ph;
            p  = int'($urandom_range(2, 20));
            h  = int'($urandom_range(1, p - 1));
            ph = int'($urandom_range(1, 8));
            if ($urandom_range(0, 4) == 0) begin
                #1 en = 1'b0;
                repeat (int'($urandom_range(1, 6))) @(posedge clk);
                #2 en = 1'b1;
            end
            align(ph);
            wave(p, h, int'($urandom_range(2, 5)), ph);
        end
        repeat (5) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/period_meter.md
PERIOD_METER -- requirements
Module: period_meter

Interface
REQ-001 Parameter WIDTH, default 32, is the width of the measurement counters and result outputs.
REQ-002 Parameter SYNC_STAGES, default 2, minimum 2, is the number of synchroniser flops on SIG_in.
REQ-003 CLK_in  input  1  sole clock, rising-edge active.
REQ-004 RST_in  input  1  asynchronous, active-high reset.
REQ-005 EN_in  input  1  measurement enable, synchronous to CLK_in.
REQ-006 SIG_in  input  1  signal under measurement, asynchronous to CLK_in.
REQ-007 PERIOD_out  output  WIDTH  last measured period, in CLK_in cycles.
REQ-008 HIGH_out  output  WIDTH  last measured high time, in CLK_in cycles.
REQ-009 VALID_out  output  1  one-cycle pulse marking a PERIOD_out/HIGH_out update.
REQ-010 TIMEOUT_out  output  1  one-cycle pulse when the counter saturates with no rising edge.
REQ-011 BUSY_out  output  1  high while the state is ARM or MEASURE.

Function
REQ-012 SIG_in SHALL pass through a SYNC_STAGES-flop synchroniser and then one edge-detect flop; a rising or falling edge SHALL be detected on the cycle after the last synchroniser flop changes.
REQ-013 The state machine SHALL have three states: IDLE, ARM and MEASURE.
REQ-014 IDLE -> ARM when EN_in=1; any state -> IDLE on the cycle EN_in=0, with counters cleared and no VALID_out or TIMEOUT_out pulse.
REQ-015 ARM -> MEASURE on the first detected rising edge; the period counter SHALL be loaded with 1 and the high-time register SHALL be cleared.
REQ-016 In MEASURE, the period counter SHALL increment by 1 every cycle with no rising edge.
REQ-017 In MEASURE, a detected falling edge SHALL copy the current counter value into the high-time register; only the first falling edge per period is captured.
REQ-018 In MEASURE, a detected rising edge SHALL register PERIOD_out <= counter and HIGH_out <= high-time register, pulse VALID_out on the next cycle, reload the counter with 1, and remain in MEASURE.
REQ-019 A periodic SIG_in of P cycles with H high cycles SHALL yield PERIOD_out=P and HIGH_out=H, exact for P>=2 once synchronised.
REQ-020 VALID_out SHALL coincide with the first cycle on which the new PERIOD_out/HIGH_out values are visible.
REQ-021 When the counter reaches 2^WIDTH-1 with no rising edge, the block SHALL pulse TIMEOUT_out for one cycle, leave PERIOD_out/HIGH_out unchanged, and go to ARM.
REQ-022 If a rising edge and saturation occur on the same cycle, the rising edge SHALL win: VALID_out pulses and TIMEOUT_out does not.
REQ-023 If no falling edge occurs within a period, HIGH_out SHALL equal PERIOD_out on that update.
REQ-024 PERIOD_out and HIGH_out SHALL hold their last values through IDLE and ARM.
REQ-025 All counter arithmetic SHALL be unsigned WIDTH-bit and SHALL never wrap.

Reset
REQ-026 RST_in=1 SHALL immediately force state IDLE and clear the synchroniser, edge flop and counters.
REQ-027 RST_in=1 SHALL immediately force PERIOD_out=0, HIGH_out=0, VALID_out=0, TIMEOUT_out=0 and BUSY_out=0.
REQ-028 After RST_in deasserts, the first rising edge SHALL only arm the block; the first VALID_out SHALL follow the second rising edge.

Structure
REQ-029 The state encoding (IDLE/ARM/MEASURE) and the constant SYNC_MIN=2 SHALL live in the shared package.
REQ-030 The synchroniser plus edge detector SHALL be one sub-module, sync_edge_detect, with outputs rise_pulse and fall_pulse.
REQ-031 No logic SHALL be clocked by SIG_in; everything runs on CLK_in.

Verification
REQ-032 EN_in=1, SIG_in square wave, period 16, 8 high -> first VALID_out after the second rising edge; PERIOD_out=16, HIGH_out=8; VALID_out every 16 cycles thereafter.
REQ-033 SIG_in period 10, 3 high, phase-shifted relative to CLK_in -> PERIOD_out=10, HIGH_out=3 on every update.
REQ-034 WIDTH=8, one rising edge then SIG_in held low -> TIMEOUT_out pulses exactly once, 255 cycles after arming; state returns to ARM; outputs unchanged.
REQ-035 EN_in dropped mid-period, then re-raised -> no VALID_out during the partial period; outputs hold; two new rising edges are needed before the next VALID_out.
REQ-036 RST_in asserted mid-MEASURE, asynchronously to CLK_in -> all outputs 0 in the same cycle; after release with a 16-cycle wave, the first VALID_out follows the second rising edge.
REQ-037 SIG_in constant 1 from reset with EN_in=1 -> no VALID_out ever; BUSY_out=1; no TIMEOUT_out, because the block never leaves ARM.
